// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes,
// FSM state encoding and the default datapath width.
package muldiv_unit_pkg;
    localparam int DEFAULT_WIDTH = 32;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return op[0];
    endfunction
endpackage

// File: rtl/muldiv_unit_if.sv
// Execute-stage bus between the controller and the multiply/divide unit.
// Handshake: start is taken only when busy=0; busy rises the cycle after acceptance, done pulses once when HI/LO hold the result.
interface muldiv_unit_if #(parameter int WIDTH = 32);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic [1:0]       dbg_state;

    modport master (
        output start, op, a, b, hi_we, lo_we, wd,
        input  hi, lo, busy, done, dbg_state
    );

    modport slave (
        input  start, op, a, b, hi_we, lo_we, wd,
        output hi, lo, busy, done, dbg_state
    );
endinterface

// File: rtl/muldiv_unit_step.sv
// One combinational iteration: shift-add for multiply on {acc, multiplier},
// restoring shift-subtract for divide on {rem, quotient}.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] upper,
    input  logic [WIDTH-1:0] lower,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] upper_nx,
    output logic [WIDTH-1:0] lower_nx
);
    logic [WIDTH:0] sum;
    logic [WIDTH:0] sh;
    logic [WIDTH:0] trial;

    always_comb begin
        sum      = '0;
        sh       = '0;
        trial    = '0;
        upper_nx = upper;
        lower_nx = lower;
        if (is_div) begin
            sh    = {upper, lower[WIDTH-1]};
            trial = sh - {1'b0, operand};
            // A clear sign bit means the divisor fits: keep the difference, quotient bit 1.
            if (!trial[WIDTH]) begin
                upper_nx = trial[WIDTH-1:0];
                lower_nx = {lower[WIDTH-2:0], 1'b1};
            end else begin
                upper_nx = sh[WIDTH-1:0];
                lower_nx = {lower[WIDTH-2:0], 1'b0};
            end
        end else begin
            sum      = lower[0] ? ({1'b0, upper} + {1'b0, operand}) : {1'b0, upper};
            upper_nx = sum[WIDTH:1];
            lower_nx = {sum[0], lower[WIDTH-1:1]};
        end
    end
endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Works on magnitudes for WIDTH cycles, then applies signs in FIX.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic         clk,
    input  logic         reset,
    muldiv_unit_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int PW    = 2 * WIDTH;

    logic [1:0]       state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] upper_q, upper_d;
    logic [WIDTH-1:0] lower_q, lower_d;
    logic [WIDTH-1:0] operand_q, operand_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             neg_q, neg_d;
    logic             neg_rem_q, neg_rem_d;
    logic             bzero_q, bzero_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             sa, sb;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH-1:0] step_upper, step_lower;
    logic [PW-1:0]    prod, prod_s;
    logic [WIDTH-1:0] quo_s, rem_s;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div   (op_is_div(op_q)),
        .upper    (upper_q),
        .lower    (lower_q),
        .operand  (operand_q),
        .upper_nx (step_upper),
        .lower_nx (step_lower)
    );

    assign sa    = op_is_signed(bus.op) & bus.a[WIDTH-1];
    assign sb    = op_is_signed(bus.op) & bus.b[WIDTH-1];
    assign mag_a = sa ? (~bus.a + WIDTH'(1)) : bus.a;
    assign mag_b = sb ? (~bus.b + WIDTH'(1)) : bus.b;

    assign prod   = {upper_q, lower_q};
    assign prod_s = neg_q ? (~prod + PW'(1)) : prod;
    assign quo_s  = neg_q ? (~lower_q + WIDTH'(1)) : lower_q;
    // Divide by zero leaves the dividend magnitude in rem, so the signed remainder is the raw a.
    assign rem_s  = neg_rem_q ? (~upper_q + WIDTH'(1)) : upper_q;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        upper_d   = upper_q;
        lower_d   = lower_q;
        operand_d = operand_q;
        count_d   = count_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        bzero_d   = bzero_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    op_d      = bus.op;
                    upper_d   = '0;
                    lower_d   = op_is_div(bus.op) ? mag_a : mag_b;
                    operand_d = op_is_div(bus.op) ? mag_b : mag_a;
                    neg_d     = sa ^ sb;
                    neg_rem_d = sa;
                    bzero_d   = (bus.b == '0);
                    count_d   = '0;
                    state_d   = ST_RUN;
                end else begin
                    if (bus.hi_we) hi_d = bus.wd;
                    if (bus.lo_we) lo_d = bus.wd;
                end
            end
            ST_RUN: begin
                upper_d = step_upper;
                lower_d = step_lower;
                count_d = count_q + CNT_W'(1);
                if (count_q == CNT_W'(WIDTH - 1)) state_d = ST_FIX;
            end
            ST_FIX: begin
                if (op_is_div(op_q)) begin
                    lo_d = bzero_q ? '1 : quo_s;
                    hi_d = rem_s;
                end else begin
                    hi_d = prod_s[PW-1:WIDTH];
                    lo_d = prod_s[WIDTH-1:0];
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_q == ST_FIX);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_MULTU;
            upper_q   <= '0;
            lower_q   <= '0;
            operand_q <= '0;
            count_q   <= '0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            bzero_q   <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            upper_q   <= upper_d;
            lower_q   <= lower_d;
            operand_q <= operand_d;
            count_q   <= count_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            bzero_q   <= bzero_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus random
// operations scored against a plain-arithmetic model of HI/LO.
module tb_muldiv_unit;
    localparam int W   = 32;
    localparam int LAT = W + 1;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    logic [2*W-1:0] exp_q[$];

    muldiv_unit_if #(.WIDTH(W)) bus ();

    muldiv_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: HI/LO straight from integer arithmetic.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] qv, rv, p;
        sa = $signed(a);
        sb = $signed(b);
        p  = '0;
        case (op)
            2'b00: p = {32'd0, a} * {32'd0, b};
            2'b01: p = sa * sb;
            2'b10: p = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
            default: begin
                if (b == 0) p = {a, 32'hFFFF_FFFF};
                else begin
                    q  = sa / sb;
                    r  = sa % sb;
                    qv = q;
                    rv = r;
                    p  = {rv[31:0], qv[31:0]};
                end
            end
        endcase
        return p;
    endfunction

    // driver: hold start for one edge; returns #1 after the accepting edge
    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic with_hi_we);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        bus.hi_we = with_hi_we;
        bus.wd    = 32'hDEAD_BEEF;
        exp_q.push_back(model(op, a, b));
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.hi_we = 1'b0;
        bus.op    = 2'($urandom_range(0, 3));
        bus.a     = $urandom;
        bus.b     = $urandom;
    endtask

    task automatic wait_done(input string tag, input int exp_lat, input bit check_pulse);
        int n;
        int gap;
        logic [63:0] e;
        n   = 0;
        gap = 0;
        if (!bus.busy) gap++;
        while (n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.done) break;
            if (!bus.busy) gap++;
        end
        check_val({tag, "_latency"}, 64'(n), 64'(exp_lat));
        check_val({tag, "_busy_gap"}, 64'(gap), 64'd0);
        check_val({tag, "_busy_at_done"}, 64'(bus.busy), 64'd0);
        if (exp_q.size() == 0) check_val({tag, "_sb_empty"}, 64'd0, 64'd1);
        else begin
            e = exp_q.pop_front();
            check_val({tag, "_hilo"}, {bus.hi, bus.lo}, e);
        end
        if (check_pulse) begin
            @(posedge clk);
            #1;
            check_val({tag, "_done_width"}, 64'(bus.done), 64'd0);
        end
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = '0;
        bus.b     = '0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        bus.wd    = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check_val("rst_hilo", {bus.hi, bus.lo}, 64'd0);
        check_val("rst_busy_done", {62'd0, bus.busy, bus.done}, 64'd0);
        check_val("rst_state", 64'(bus.dbg_state), 64'd0);
        @(posedge clk);
        #1;

        // directed corner cases
        start_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        wait_done("multu_max", LAT, 1'b1);
        start_op(2'b01, 32'hFFFF_FFFD, 32'd5, 1'b0);
        wait_done("mult_neg", LAT, 1'b1);
        start_op(2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0);
        wait_done("div_neg", LAT, 1'b1);
        start_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        wait_done("div_ovf", LAT, 1'b1);
        start_op(2'b10, 32'd100, 32'd0, 1'b0);
        wait_done("divu_zero", LAT, 1'b1);
        start_op(2'b11, 32'hFFFF_FF00, 32'd0, 1'b0);
        wait_done("div_zero_neg", LAT, 1'b1);

        // start / MTHI / MTLO while busy are dropped
        start_op(2'b00, 32'd3, 32'd4, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.op    = 2'b11;
        bus.a     = 32'd9;
        bus.b     = 32'd9;
        bus.hi_we = 1'b1;
        bus.lo_we = 1'b1;
        bus.wd    = 32'h0000_DEAD;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        wait_done("busy_ignore", LAT - 6, 1'b1);

        // asynchronous reset in the middle of RUN
        start_op(2'b01, 32'h1234_5678, 32'h8765_4321, 1'b0);
        repeat (9) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_val("midrun_rst_hilo", {bus.hi, bus.lo}, 64'd0);
        check_val("midrun_rst_busy", 64'(bus.busy), 64'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_val("post_rst_idle", {62'd0, bus.busy, bus.done}, 64'd0);
        start_op(2'b00, 32'd6, 32'd7, 1'b0);
        wait_done("after_rst_6x7", LAT, 1'b1);

        // MTHI then MTLO
        bus.hi_we = 1'b1;
        bus.wd    = 32'h1234_5678;
        @(posedge clk);
        #1;
        bus.hi_we = 1'b0;
        check_val("mthi", 64'(bus.hi), 64'h1234_5678);
        bus.lo_we = 1'b1;
        bus.wd    = 32'h9ABC_DEF0;
        @(posedge clk);
        #1;
        bus.lo_we = 1'b0;
        check_val("mtlo", {bus.hi, bus.lo}, 64'h1234_5678_9ABC_DEF0);
        bus.hi_we = 1'b1;
        bus.lo_we = 1'b1;
        bus.wd    = 32'h0BAD_F00D;
        @(posedge clk);
        #1;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        check_val("mthi_mtlo_both", {bus.hi, bus.lo}, 64'h0BAD_F00D_0BAD_F00D);

        // start wins over a simultaneous MTHI
        start_op(2'b00, 32'h0001_0000, 32'h0003_0000, 1'b1);
        wait_done("start_vs_mthi", LAT, 1'b0);

        // random ops, each started in the done cycle of the previous one
        for (int i = 0; i < 24; i++) begin
            start_op(2'($urandom_range(0, 3)), pick_operand(), pick_operand(), 1'($urandom_range(0, 1)));
            wait_done($sformatf("rand%0d", i), LAT, (i == 23));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
